pz_axil_loader: RTL and testbench

- AXI-Lite initiator that pushes a shadow bank of pole/zero coefficient words into the pixel generator's AXI-Lite register file. It writes NUM_WORDS words to consecutive word addresses starting at BASE_ADDR.
- Used in place of the PS for standalone and animated pole/zero demos. It sits in the same clock domain as the pixel generator's register slave.
- Each word is one 32-bit value, {re[15:0], im[15:0]}, signed Q-format. The loader passes it through untouched.

---
 rtl/pz_axil_loader.sv | 212 +++++++++++++++++++++
 tb/tb_pz_axil_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pz_axil_loader.sv
// pz_axil_loader: AXI-Lite initiator that copies a shadow bank of pole/zero
// coefficient words into consecutive word registers starting at BASE_ADDR.
// One write is outstanding at a time; words pass through untouched.
// Optional build macro: PZ_LOADER_READBACK_EN adds a read-back verify pass
// ahead of DONE. Without it the read channel is tied off.
module pz_axil_loader #(
  parameter int NUM_WORDS = 8,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [31:0]       cfg_wdata,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_idx,
  output logic [ADDR_W-1:0] m_axi_lite_awaddr,
  output logic              m_axi_lite_awvalid,
  input  logic              m_axi_lite_awready,
  output logic [31:0]       m_axi_lite_wdata,
  output logic [3:0]        m_axi_lite_wstrb,
  output logic              m_axi_lite_wvalid,
  input  logic              m_axi_lite_wready,
  input  logic [1:0]        m_axi_lite_bresp,
  input  logic              m_axi_lite_bvalid,
  output logic              m_axi_lite_bready,
  output logic [ADDR_W-1:0] m_axi_lite_araddr,
  output logic              m_axi_lite_arvalid,
  input  logic              m_axi_lite_arready,
  input  logic [31:0]       m_axi_lite_rdata,
  input  logic [1:0]        m_axi_lite_rresp,
  input  logic              m_axi_lite_rvalid,
  output logic              m_axi_lite_rready
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_WAIT_B = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef PZ_LOADER_READBACK_EN
  localparam logic [2:0] S_RD_AR  = 3'd4;
  localparam logic [2:0] S_RD_R   = 3'd5;
`endif

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_err;
  logic [IDX_W-1:0]  r_err_idx;
  logic              r_awvalid;
  logic              r_wvalid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_shadow [NUM_WORDS];

  logic              w_cfg_hit;
  logic [31:0]       w_word0;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_last;
  logic              w_aw_ok;
  logic              w_w_ok;

  // Byte address of a word index, truncated to the bus width (wrap allowed).
  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
    logic [31:0] full;
    full = 32'(BASE_ADDR) + (32'(idx) << 2);
    return full[ADDR_W-1:0];
  endfunction

  // Shadow edits are accepted only while idle and only for in-range indices.
  assign w_cfg_hit = cfg_we && (r_state == S_IDLE) &&
                     (32'(cfg_idx) < 32'(NUM_WORDS));
  // Forward a same-cycle edit of word 0 so a coincident start loads the new value.
  assign w_word0   = (w_cfg_hit && (cfg_idx == '0)) ? cfg_wdata : r_shadow[0];
  assign w_idx_nxt = r_idx + IDX_W'(1);
  assign w_last    = (r_idx == IDX_W'(NUM_WORDS - 1));
  // Each channel is finished once its valid is low or handshakes this edge.
  assign w_aw_ok   = !r_awvalid || m_axi_lite_awready;
  assign w_w_ok    = !r_wvalid  || m_axi_lite_wready;

  // Shadow bank storage; deliberately left out of reset.
  always_ff @(posedge aclk) begin
    if (w_cfg_hit) r_shadow[cfg_idx] <= cfg_wdata;
  end

`ifdef PZ_LOADER_READBACK_EN
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic              w_rd_bad;

  assign w_rd_bad = (m_axi_lite_rresp != 2'b00) ||
                    (m_axi_lite_rdata != r_shadow[r_idx]);
`endif

  // Load sequencer: write each word, wait for its B, then optionally verify.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
`ifdef PZ_LOADER_READBACK_EN
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= addr_of('0);
            r_wdata   <= w_word0;
            r_state   <= S_WR;
          end
        end
        S_WR: begin
          r_awvalid <= r_awvalid && !m_axi_lite_awready;
          r_wvalid  <= r_wvalid  && !m_axi_lite_wready;
          if (w_aw_ok && w_w_ok) r_state <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (m_axi_lite_bvalid) begin
            if ((m_axi_lite_bresp != 2'b00) && !r_err) begin
              r_err     <= 1'b1;
              r_err_idx <= r_idx;
            end
            if (w_last) begin
`ifdef PZ_LOADER_READBACK_EN
              r_idx     <= '0;
              r_arvalid <= 1'b1;
              r_araddr  <= addr_of('0);
              r_state   <= S_RD_AR;
`else
              r_state   <= S_DONE;
`endif
            end else begin
              r_idx     <= w_idx_nxt;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= addr_of(w_idx_nxt);
              r_wdata   <= r_shadow[w_idx_nxt];
              r_state   <= S_WR;
            end
          end
        end
`ifdef PZ_LOADER_READBACK_EN
        S_RD_AR: begin
          if (m_axi_lite_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (m_axi_lite_rvalid) begin
            if (w_rd_bad && !r_err) begin
              r_err     <= 1'b1;
              r_err_idx <= r_idx;
            end
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx     <= w_idx_nxt;
              r_arvalid <= 1'b1;
              r_araddr  <= addr_of(w_idx_nxt);
              r_state   <= S_RD_AR;
            end
          end
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy               = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done               = (r_state == S_DONE);
  assign err                = r_err;
  assign err_idx            = r_err_idx;
  assign m_axi_lite_awaddr  = r_awaddr;
  assign m_axi_lite_awvalid = r_awvalid;
  assign m_axi_lite_wdata   = r_wdata;
  assign m_axi_lite_wstrb   = 4'hF;
  assign m_axi_lite_wvalid  = r_wvalid;
  assign m_axi_lite_bready  = (r_state == S_WAIT_B);

`ifdef PZ_LOADER_READBACK_EN
  assign m_axi_lite_araddr  = r_araddr;
  assign m_axi_lite_arvalid = r_arvalid;
  assign m_axi_lite_rready  = (r_state == S_RD_R);
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{m_axi_lite_arready, m_axi_lite_rvalid,
                         m_axi_lite_rresp, m_axi_lite_rdata};
  assign m_axi_lite_araddr  = '0;
  assign m_axi_lite_arvalid = 1'b0;
  assign m_axi_lite_rready  = 1'b0;
`endif

endmodule

// File: tb/tb_pz_axil_loader.sv
// Directed testbench for pz_axil_loader (8 words, 8-bit addresses, base 0).
// Honours PZ_LOADER_READBACK_EN when the same define is given to the build.
`timescale 1ns/1ps
module tb_pz_axil_loader;
  localparam int NW = 8;
  localparam int AW = 8;
  localparam int IW = 3;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [31:0]   cfg_wdata;
  logic          start;
  logic          busy, done, err;
  logic [IW-1:0] err_idx;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_shadow [NW];

  always #5 aclk = ~aclk;

  pz_axil_loader #(.NUM_WORDS(NW), .ADDR_W(AW), .BASE_ADDR(0), .IDX_W(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy), .done(done), .err(err), .err_idx(err_idx),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid),
    .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid),
    .m_axi_lite_bready(bready), .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid),
    .m_axi_lite_arready(arready), .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
    .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Acts as the slave for one word: readies after the given latencies, then one B.
  task automatic serve_word(input int idx, input int aw_lat, input int w_lat,
                            input logic [1:0] resp, input bit hold_b);
    bit aw_got = 1'b0;
    bit w_got  = 1'b0;
    int c = 0;
    logic [31:0] exp_addr;
    exp_addr = 32'(idx * 4);
    chk($sformatf("done_low_w%0d", idx), done, 0);
    while (!(aw_got && w_got) && c < 40) begin
      awready = (c >= aw_lat) && !aw_got;
      wready  = (c >= w_lat) && !w_got;
      if (!aw_got) begin
        chk($sformatf("awvalid_hi_w%0d", idx), awvalid, 1);
        chk($sformatf("awaddr_w%0d", idx), awaddr, exp_addr);
      end else chk($sformatf("awvalid_lo_w%0d", idx), awvalid, 0);
      if (!w_got) begin
        chk($sformatf("wvalid_hi_w%0d", idx), wvalid, 1);
        chk($sformatf("wdata_w%0d", idx), wdata, m_shadow[idx]);
      end else chk($sformatf("wvalid_lo_w%0d", idx), wvalid, 0);
      chk($sformatf("bready_wr_w%0d", idx), bready, 0);
      chk($sformatf("arvalid_wr_w%0d", idx), arvalid, 0);
      chk($sformatf("busy_wr_w%0d", idx), busy, 1);
      if (awvalid && awready) aw_got = 1'b1;
      if (wvalid && wready) w_got = 1'b1;
      tick();
      cfg_we = 1'b0;
      c++;
    end
    chk($sformatf("wr_handshakes_w%0d", idx), {30'd0, aw_got, w_got}, 32'd3);
    awready = 1'b0;
    wready  = 1'b0;
    chk($sformatf("bready_wb_w%0d", idx), bready, 1);
    chk($sformatf("awvalid_wb_w%0d", idx), awvalid, 0);
    chk($sformatf("wvalid_wb_w%0d", idx), wvalid, 0);
    if (!hold_b) begin
      bvalid = 1'b1;
      bresp  = resp;
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      chk($sformatf("bready_after_w%0d", idx), bready, 0);
    end
  endtask

  // Verify pass (only present with the read-back build).
  task automatic finish_load(input int corrupt);
`ifdef PZ_LOADER_READBACK_EN
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("arvalid_hi_r%0d", i), arvalid, 1);
      chk($sformatf("araddr_r%0d", i), araddr, 32'(i * 4));
      chk($sformatf("busy_rd_r%0d", i), busy, 1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk($sformatf("arvalid_lo_r%0d", i), arvalid, 0);
      chk($sformatf("rready_hi_r%0d", i), rready, 1);
      rvalid = 1'b1;
      rresp  = 2'b00;
      rdata  = (i == corrupt) ? ~m_shadow[i] : m_shadow[i];
      tick();
      rvalid = 1'b0;
      chk($sformatf("rready_lo_r%0d", i), rready, 0);
    end
`else
    chk("no_rd_arvalid", arvalid, 0);
    chk("no_rd_corrupt_arg", 32'(corrupt), 32'(corrupt < 0 ? -1 : corrupt));
`endif
  endtask

  // One complete load, with optional slow AW, error responses and shadow edits.
  task automatic run_load(input logic [7:0] bmask, input int slow_word, input int corrupt,
                          input bit start_we, input bit busy_we);
    if (start_we) begin
      cfg_we = 1'b1; cfg_idx = 3'd1; cfg_wdata = 32'hDEAD_BEEF;
      m_shadow[1] = 32'hDEAD_BEEF;
    end
    start = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    chk("err_clr_on_start", err, 0);
    chk("err_idx_clr_on_start", err_idx, 0);
    chk("busy_on_start", busy, 1);
    if (busy_we) begin
      cfg_we = 1'b1; cfg_idx = 3'd1; cfg_wdata = 32'h0;
    end
    for (int i = 0; i < NW; i++)
      serve_word(i, (i == slow_word) ? 3 : 0, 0, bmask[i] ? 2'b10 : 2'b00, 1'b0);
    finish_load(corrupt);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    tick();
    chk("done_cleared", done, 0);
    chk("busy_idle", busy, 0);
    chk("awvalid_idle", awvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0; start = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    tick(); tick(); tick();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_araddr", araddr, 0);
    chk("wstrb", wstrb, 4'hF);
    aresetn = 1'b1;
    tick();

    for (int i = 0; i < NW; i++) begin
      cfg_we = 1'b1; cfg_idx = IW'(i); cfg_wdata = 32'h0001_0000 * i;
      m_shadow[i] = 32'h0001_0000 * i;
      tick();
    end
    cfg_we = 1'b0;

    // Ideal slave load
    run_load(8'h00, -1, -1, 1'b0, 1'b0);
    chk("t1_err", err, 0);

    // W accepted three cycles ahead of AW on word 2
    run_load(8'h00, 2, -1, 1'b0, 1'b0);
    chk("t2_err", err, 0);

    // SLVERR on words 3 and 5: first failure recorded
    run_load(8'b0010_1000, -1, -1, 1'b0, 1'b0);
    chk("t3_err", err, 1);
    chk("t3_err_idx", err_idx, 3);
    tick();
    chk("t3_err_sticky", err, 1);

    // Reset while waiting for B of word 4
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_err_clr", err, 0);
    for (int i = 0; i < 4; i++) serve_word(i, 0, 0, 2'b00, 1'b0);
    serve_word(4, 0, 0, 2'b00, 1'b1);
    chk("t4_in_waitb", bready, 1);
    aresetn = 1'b0;
    tick();
    chk("t4_awvalid", awvalid, 0);
    chk("t4_wvalid", wvalid, 0);
    chk("t4_bready", bready, 0);
    chk("t4_arvalid", arvalid, 0);
    chk("t4_rready", rready, 0);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    aresetn = 1'b1;
    tick();
    chk("t4_idle_busy", busy, 0);
    run_load(8'h00, -1, -1, 1'b0, 1'b0);
    chk("t4_reload_err", err, 0);

    // Shadow edit alongside start, then an ignored edit while busy
    run_load(8'h00, -1, -1, 1'b1, 1'b1);
    run_load(8'h00, -1, -1, 1'b0, 1'b0);
    chk("t5_err", err, 0);

`ifdef PZ_LOADER_READBACK_EN
    // Read-back catches corrupted word 6
    run_load(8'h00, -1, 6, 1'b0, 1'b0);
    chk("t6_err", err, 1);
    chk("t6_err_idx", err_idx, 6);
`else
    chk("t6_arvalid_tied", arvalid, 0);
    chk("t6_rready_tied", rready, 0);
    chk("t6_araddr_tied", araddr, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
